// File: rtl/reg_move_ctrl.sv
// -----------------------------------------------------------------------------
// reg_move_ctrl
//
// Sequencer on the initiator side of the 16x8 register file port. It takes one
// command at a time from the instruction decoder and runs it against the
// register file's single address port:
//   MOV  (op 00) : copy len+1 registers from src.. to dst.., ascending order
//   SWAP (op 01) : exchange registers src and dst
//   FILL (op 10) : write imm into len+1 registers starting at dst
//   op 11        : reserved, completes at once with err=1
//
// Ports
//   clk        system clock, rising edge
//   CLB        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  high only while IDLE
//   cmd_op     operation code
//   cmd_src    source start address (MOV, SWAP)
//   cmd_dst    destination start address
//   cmd_len    element count minus one (MOV, FILL)
//   cmd_imm    fill value (FILL)
//   done       one-cycle pulse when a command completes
//   err        qualifies done; set only for the reserved op
//   RegAddr    register file address
//   reg_in     register file write data
//   LoadReg    register file write enable
//   reg_out    register file read data, combinational from RegAddr
//   state_dbg  current FSM state encoding (observation only)
//
// Handshake: a command is taken at a rising edge where cmd_valid && cmd_ready.
// cmd_ready is a pure decode of the IDLE state, so it never depends on
// cmd_valid, and every cmd_* field is latched at that same edge. cmd_valid may
// stay high while busy; nothing else is taken until the FSM is back in IDLE.
//
// All datapath outputs decode from registered state only, so there is no
// combinational path from cmd_* to RegAddr, reg_in or LoadReg.
// -----------------------------------------------------------------------------
module reg_move_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          CLB,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_imm,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] RegAddr,
  output logic [DW-1:0] reg_in,
  output logic          LoadReg,
  input  logic [DW-1:0] reg_out,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_SW_RD2 = 3'd3,
    S_SW_WR1 = 3'd4,
    S_SW_WR2 = 3'd5,
    S_FILL   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [1:0]    OP_MOV  = 2'b00;
  localparam logic [1:0]    OP_SWAP = 2'b01;
  localparam logic [1:0]    OP_FILL = 2'b10;
  localparam logic [AW-1:0] A_ONE   = AW'(1);

  state_t        state;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] cnt;
  logic [DW-1:0] hold_a;
  logic [DW-1:0] hold_b;
  logic [DW-1:0] imm;
  logic          is_swap;
  logic          err_q;

  // Single state/datapath process. Address increments wrap naturally at AW
  // bits, which gives the modulo-16 addressing.
  always_ff @(posedge clk) begin
    if (CLB) begin
      state   <= S_IDLE;
      src     <= '0;
      dst     <= '0;
      cnt     <= '0;
      hold_a  <= '0;
      hold_b  <= '0;
      imm     <= '0;
      is_swap <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            src     <= cmd_src;
            dst     <= cmd_dst;
            cnt     <= cmd_len;
            imm     <= cmd_imm;
            is_swap <= (cmd_op == OP_SWAP);
            err_q   <= (cmd_op == 2'b11);
            case (cmd_op)
              OP_MOV:  state <= S_RD;
              OP_SWAP: state <= S_RD;
              OP_FILL: state <= S_FILL;
              default: state <= S_DONE;
            endcase
          end
        end
        // Shared read of src: MOV element read, or first SWAP read.
        S_RD: begin
          hold_a <= reg_out;
          state  <= is_swap ? S_SW_RD2 : S_WR;
        end
        S_WR: begin
          if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            src   <= src + A_ONE;
            dst   <= dst + A_ONE;
            cnt   <= cnt - A_ONE;
            state <= S_RD;
          end
        end
        S_SW_RD2: begin
          hold_b <= reg_out;
          state  <= S_SW_WR1;
        end
        S_SW_WR1: state <= S_SW_WR2;
        S_SW_WR2: state <= S_DONE;
        S_FILL: begin
          if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            dst <= dst + A_ONE;
            cnt <= cnt - A_ONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from registered state.
  always_comb begin
    cmd_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    RegAddr   = '0;
    reg_in    = '0;
    LoadReg   = 1'b0;
    case (state)
      S_IDLE:   cmd_ready = 1'b1;
      S_RD:     RegAddr = src;
      S_WR: begin
        RegAddr = dst;
        reg_in  = hold_a;
        LoadReg = 1'b1;
      end
      S_SW_RD2: RegAddr = dst;
      S_SW_WR1: begin
        RegAddr = dst;
        reg_in  = hold_a;
        LoadReg = 1'b1;
      end
      S_SW_WR2: begin
        RegAddr = src;
        reg_in  = hold_b;
        LoadReg = 1'b1;
      end
      S_FILL: begin
        RegAddr = dst;
        reg_in  = imm;
        LoadReg = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_reg_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_move_ctrl
//
// Directed bench for reg_move_ctrl. A 16x8 register file model sits on the
// DUT's register port (combinational read, write on rising edge when LoadReg).
// Expected register contents, latencies and address traces are hand-computed
// constants. Inputs change on the falling edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_reg_move_ctrl;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic CLB = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT signals
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op    = 2'b00;
  logic [3:0] cmd_src   = 4'd0;
  logic [3:0] cmd_dst   = 4'd0;
  logic [3:0] cmd_len   = 4'd0;
  logic [7:0] cmd_imm   = 8'd0;
  logic       done;
  logic       err;
  logic [3:0] RegAddr;
  logic [7:0] reg_in;
  logic       LoadReg;
  logic [7:0] reg_out;
  logic [2:0] state_dbg;

  reg_move_ctrl #(.AW(4), .DW(8)) dut (
    .clk       (clk),
    .CLB       (CLB),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .cmd_imm   (cmd_imm),
    .done      (done),
    .err       (err),
    .RegAddr   (RegAddr),
    .reg_in    (reg_in),
    .LoadReg   (LoadReg),
    .reg_out   (reg_out),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------- reg file model
  logic [7:0] rf [16];
  logic       pre_we  = 1'b0;
  logic [3:0] pre_idx = 4'd0;
  logic [7:0] pre_dat = 8'd0;
  int         wr_cnt  = 0;
  int         acc_cnt = 0;

  assign reg_out = rf[RegAddr];

  always @(posedge clk) begin
    if (pre_we)       rf[pre_idx] <= pre_dat;
    else if (LoadReg) rf[RegAddr] <= reg_in;
    if (LoadReg)               wr_cnt  <= wr_cnt + 1;
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  // ---------------------------------------------------------------- scoreboard
  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic poke(input int idx, input logic [7:0] v);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = 4'(idx);
    pre_dat = v;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  // Presents a command and returns right at its accept edge. cmd_valid stays
  // high until wait_done drops it.
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] src,
                          input logic [3:0] dst, input logic [3:0] len,
                          input logic [7:0] imm);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  // lat = number of edges after the accept edge before done is seen.
  // got_q collects RegAddr for every busy cycle.
  task automatic wait_done(output int lat, output logic e);
    got_q.delete();
    lat = 0;
    @(negedge clk);
    while (!done && lat < 100) begin
      got_q.push_back({4'd0, RegAddr});
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    e = err;
    check("done_noload", {31'd0, LoadReg}, 32'd0);
    check("done_noready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    int   lat;
    logic e;
    int   w0, a0, dn;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    CLB = 1'b0;
    check("rst_ready",  {31'd0, cmd_ready}, 32'd1);
    check("rst_done",   {31'd0, done},      32'd0);
    check("rst_err",    {31'd0, err},       32'd0);
    check("rst_addr",   {28'd0, RegAddr},   32'd0);
    check("rst_regin",  {24'd0, reg_in},    32'd0);
    check("rst_load",   {31'd0, LoadReg},   32'd0);

    // Reset mid-MOV: R0..R15 = 0x10..0x1F, MOV 0 -> 8, 8 elements.
    for (int i = 0; i < 16; i++) poke(i, 8'(8'h10 + i));
    w0 = wr_cnt;
    send_cmd(2'b00, 4'd0, 4'd8, 4'd7, 8'h00);
    repeat (3) @(negedge clk);     // first element written to R8
    cmd_valid = 1'b0;
    CLB = 1'b1;
    @(negedge clk);
    CLB = 1'b0;
    check("mrst_ready", {31'd0, cmd_ready}, 32'd1);
    check("mrst_load",  {31'd0, LoadReg},   32'd0);
    check("mrst_addr",  {28'd0, RegAddr},   32'd0);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("mrst_nodone", 32'(dn), 32'd0);
    check("mrst_writes", 32'(wr_cnt - w0), 32'd1);
    check("mrst_r8",  {24'd0, rf[8]}, 32'h10);
    check("mrst_r9",  {24'd0, rf[9]}, 32'h19);

    // MOV src=2 dst=9 len=3, cmd_valid held high through busy
    poke(2, 8'hA1); poke(3, 8'hA2); poke(4, 8'hA3); poke(5, 8'hA4);
    w0 = wr_cnt; a0 = acc_cnt;
    send_cmd(2'b00, 4'd2, 4'd9, 4'd3, 8'h00);
    wait_done(lat, e);
    check("mov_lat",  32'(lat), 32'd8);
    check("mov_err",  {31'd0, e}, 32'd0);
    check("mov_wr",   32'(wr_cnt - w0), 32'd4);
    check("mov_acc",  32'(acc_cnt - a0), 32'd1);
    check("mov_r9",   {24'd0, rf[9]},  32'hA1);
    check("mov_r10",  {24'd0, rf[10]}, 32'hA2);
    check("mov_r11",  {24'd0, rf[11]}, 32'hA3);
    check("mov_r12",  {24'd0, rf[12]}, 32'hA4);
    check("mov_r13",  {24'd0, rf[13]}, 32'h1D);

    // MOV wrap: src=14 dst=0 len=2
    poke(14, 8'h5E); poke(15, 8'h5F); poke(0, 8'h5E); poke(1, 8'h00); poke(2, 8'h00);
    w0 = wr_cnt;
    send_cmd(2'b00, 4'd14, 4'd0, 4'd2, 8'h00);
    wait_done(lat, e);
    check("wrap_lat", 32'(lat), 32'd6);
    check("wrap_wr",  32'(wr_cnt - w0), 32'd3);
    check("wrap_r0",  {24'd0, rf[0]}, 32'h5E);
    check("wrap_r1",  {24'd0, rf[1]}, 32'h5F);
    check("wrap_r2",  {24'd0, rf[2]}, 32'h5E);
    exp_q = '{8'd14, 8'd0, 8'd15, 8'd1, 8'd0, 8'd2};
    check("wrap_trace_len", 32'(got_q.size()), 32'd6);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("wrap_addr", {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});

    // SWAP 3 <-> 7
    poke(3, 8'h55); poke(7, 8'hAA);
    w0 = wr_cnt;
    send_cmd(2'b01, 4'd3, 4'd7, 4'd9, 8'h00);
    wait_done(lat, e);
    check("swap_lat", 32'(lat), 32'd4);
    check("swap_err", {31'd0, e}, 32'd0);
    check("swap_wr",  32'(wr_cnt - w0), 32'd2);
    check("swap_r3",  {24'd0, rf[3]}, 32'hAA);
    check("swap_r7",  {24'd0, rf[7]}, 32'h55);

    // SWAP 6 <-> 6
    poke(6, 8'h3C);
    w0 = wr_cnt;
    send_cmd(2'b01, 4'd6, 4'd6, 4'd0, 8'h00);
    wait_done(lat, e);
    check("swap6_lat", 32'(lat), 32'd4);
    check("swap6_wr",  32'(wr_cnt - w0), 32'd2);
    check("swap6_r6",  {24'd0, rf[6]}, 32'h3C);

    // FILL dst=13 len=4 imm=0xE7 (wraps past 15)
    w0 = wr_cnt;
    send_cmd(2'b10, 4'd0, 4'd13, 4'd4, 8'hE7);
    wait_done(lat, e);
    check("fill_lat", 32'(lat), 32'd5);
    check("fill_err", {31'd0, e}, 32'd0);
    check("fill_wr",  32'(wr_cnt - w0), 32'd5);
    check("fill_r13", {24'd0, rf[13]}, 32'hE7);
    check("fill_r14", {24'd0, rf[14]}, 32'hE7);
    check("fill_r15", {24'd0, rf[15]}, 32'hE7);
    check("fill_r0",  {24'd0, rf[0]},  32'hE7);
    check("fill_r1",  {24'd0, rf[1]},  32'hE7);
    check("fill_r12", {24'd0, rf[12]}, 32'hA4);
    check("fill_r2",  {24'd0, rf[2]},  32'h5E);

    // Reserved op
    w0 = wr_cnt;
    send_cmd(2'b11, 4'd1, 4'd2, 4'd3, 8'h00);
    wait_done(lat, e);
    check("rsv_lat", 32'(lat), 32'd0);
    check("rsv_err", {31'd0, e}, 32'd1);
    check("rsv_wr",  32'(wr_cnt - w0), 32'd0);

    // Back-to-back reserved ops with cmd_valid held: accept, DONE, IDLE, ...
    @(negedge clk);
    w0 = wr_cnt; a0 = acc_cnt; dn = 0;
    cmd_op = 2'b11; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_acc",  32'(acc_cnt - a0), 32'd5);
    check("b2b_done", 32'(dn), 32'd5);
    check("b2b_wr",   32'(wr_cnt - w0), 32'd0);
    check("b2b_idle", {31'd0, cmd_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
